// File: rtl/sqrt_iter_unit.sv
// Iterative fixed-point square root: one result bit per clock, restoring digit recurrence,
// valid/ready handshake on both sides and optional saturating round-to-nearest.
module sqrt_iter_unit #(
  parameter int unsigned W_IN   = 12,
  parameter int unsigned F_IN   = 4,
  parameter int unsigned F_OUT  = 16,
  parameter int unsigned ROUND  = 0,
  localparam int unsigned RW_RAW = W_IN + 2 * F_OUT - F_IN,
  localparam int unsigned RW     = RW_RAW + (RW_RAW % 2),
  localparam int unsigned W_OUT  = RW / 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] Q,
  output logic [W_OUT:0]   rem,
  output logic             busy
);

  localparam int unsigned SH = 2 * F_OUT - F_IN;
  localparam int unsigned CW = (W_OUT > 1) ? $clog2(W_OUT) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCalc   = 2'd1;
  localparam logic [1:0] StRounds = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    r_q, r_d;
  logic [W_OUT+1:0] rem_acc_q, rem_acc_d;
  logic [W_OUT-1:0] q_acc_q, q_acc_d;
  logic [W_OUT-1:0] q_out_q, q_out_d;
  logic [W_OUT:0]   rem_out_q, rem_out_d;

  logic [RW-1:0]    r_load;
  logic [W_OUT+3:0] pair, trial_sub;
  logic [W_OUT+1:0] trial;
  logic             trial_ge;

  assign r_load = RW'(A) << SH;

  // Radicand is consumed two bits per step from the top of r_q.
  always_comb begin
    pair      = {rem_acc_q, r_q[RW-1 -: 2]};
    trial_sub = {2'b00, q_acc_q, 2'b01};
    trial_ge  = (pair >= trial_sub);
    trial     = pair[W_OUT+1:0] - {q_acc_q, 2'b01};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    rem_acc_d = rem_acc_q;
    q_acc_d   = q_acc_q;
    q_out_d   = q_out_q;
    rem_out_d = rem_out_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          rem_acc_d = '0;
          q_acc_d   = '0;
          cnt_d     = CW'(W_OUT - 1);
          if (A == '0) begin
            r_d     = '0;
            state_d = StRounds;
          end else begin
            r_d     = r_load;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        r_d = r_q << 2;
        if (trial_ge) begin
          rem_acc_d = trial;
          q_acc_d   = (q_acc_q << 1) | W_OUT'(1);
        end else begin
          rem_acc_d = pair[W_OUT+1:0];
          q_acc_d   = q_acc_q << 1;
        end
        if (cnt_q == '0) begin
          state_d = StRounds;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StRounds: begin
        q_out_d = q_acc_q;
        // rem > q means sqrt lies above q + 0.5; an all-ones root saturates instead.
        if (ROUND != 0 && rem_acc_q > {2'b00, q_acc_q} && !(&q_acc_q)) begin
          q_out_d = q_acc_q + W_OUT'(1);
        end
        rem_out_d = rem_acc_q[W_OUT:0];
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      r_q       <= '0;
      rem_acc_q <= '0;
      q_acc_q   <= '0;
      q_out_q   <= '0;
      rem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      rem_acc_q <= rem_acc_d;
      q_acc_q   <= q_acc_d;
      q_out_q   <= q_out_d;
      rem_out_q <= rem_out_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign Q         = q_out_q;
  assign rem       = rem_out_q;

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Bench for sqrt_iter_unit: default build in truncate and round variants plus two other
// parameter sets, checked against a binary-search integer square root model via scoreboards.
module tb_sqrt_iter_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Default build (12,4,16): dut0 truncates, dut1 rounds, both share inputs.
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [11:0] a0 = '0;
  logic        in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [19:0] q0, q1;
  logic [20:0] rem0, rem1;

  // (8,0,0) rounding build, exercises saturation.
  logic        in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [7:0]  a_b = '0;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [3:0]  q_b;
  logic [4:0]  rem_b;

  // (16,3,8) truncating build, odd raw radicand width.
  logic        in_valid_c = 1'b0, out_ready_c = 1'b0;
  logic [15:0] a_c = '0;
  logic        in_ready_c, out_valid_c, busy_c;
  logic [14:0] q_c;
  logic [15:0] rem_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint q;
    longint qr;
    longint rem;
  } exp_t;

  exp_t sb0[$], sb_b[$], sb_c[$];

  always #5 clk = ~clk;

  sqrt_iter_unit #(.W_IN(12), .F_IN(4), .F_OUT(16), .ROUND(0)) u_dut0 (
    .clk(clk), .rst_(rst), .in_valid(in_valid), .in_ready(in_ready0), .A(a0),
    .out_valid(out_valid0), .out_ready(out_ready), .Q(q0), .rem(rem0), .busy(busy0)
  );

  sqrt_iter_unit #(.W_IN(12), .F_IN(4), .F_OUT(16), .ROUND(1)) u_dut1 (
    .clk(clk), .rst_(rst), .in_valid(in_valid), .in_ready(in_ready1), .A(a0),
    .out_valid(out_valid1), .out_ready(out_ready), .Q(q1), .rem(rem1), .busy(busy1)
  );

  sqrt_iter_unit #(.W_IN(8), .F_IN(0), .F_OUT(0), .ROUND(1)) u_dut_b (
    .clk(clk), .rst_(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .A(a_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .Q(q_b), .rem(rem_b), .busy(busy_b)
  );

  sqrt_iter_unit #(.W_IN(16), .F_IN(3), .F_OUT(8), .ROUND(0)) u_dut_c (
    .clk(clk), .rst_(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .A(a_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .Q(q_c), .rem(rem_c), .busy(busy_c)
  );

  function automatic longint isqrt(input longint r);
    longint lo = 0;
    longint hi = longint'(1) << 21;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  function automatic exp_t model(input longint a, input int sh, input int w_out);
    exp_t   e;
    longint r, qt;
    r     = a << sh;
    qt    = isqrt(r);
    e.q   = qt;
    e.rem = r - qt * qt;
    e.qr  = qt;
    if (4 * r > (2 * qt + 1) * (2 * qt + 1) && qt != (longint'(1) << w_out) - 1) e.qr = qt + 1;
    return e;
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if ({out_valid0, out_valid1, out_valid_b, out_valid_c} !== 4'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0000",
               {out_valid0, out_valid1, out_valid_b, out_valid_c});
    end
    checks++;
    if ({busy0, busy1, busy_b, busy_c} !== 4'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0000", {busy0, busy1, busy_b, busy_c});
    end
    checks++;
    if (q0 !== '0 || rem0 !== '0 || q1 !== '0 || rem1 !== '0) begin
      errors++;
      $display("FAIL reset_q_rem got q0=%h rem0=%h q1=%h rem1=%h want 0", q0, rem0, q1, rem1);
    end
    checks++;
    if (q_b !== '0 || rem_b !== '0 || q_c !== '0 || rem_c !== '0) begin
      errors++;
      $display("FAIL reset_q_rem_bc got %h %h %h %h want 0", q_b, rem_b, q_c, rem_c);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready0, in_ready1, in_ready_b, in_ready_c} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1111",
               {in_ready0, in_ready1, in_ready_b, in_ready_c});
    end
  endtask

  // One transaction on the default pair; cycle 1 is the cycle that begins at the accept edge.
  task automatic run_op0(input logic [11:0] a, input int stall, input int exp_lat);
    exp_t e;
    int   cyc;
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL op_in_ready a=%h got %b want 1", a, in_ready0);
    end
    in_valid  = 1'b1;
    a0        = a;
    out_ready = 1'b0;
    @(posedge clk);
    sb0.push_back(model(a, 28, 20));
    #1;
    in_valid = 1'b0;
    a0       = 12'($urandom);
    cyc      = 1;
    while (out_valid0 !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != exp_lat) begin
      errors++;
      $display("FAIL op_latency a=%h got %0d want %0d", a, cyc, exp_lat);
    end
    e = sb0[0];
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a0       = 12'h555;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid0, in_ready0, busy0} !== 3'b101 || q0 !== 20'(e.q) ||
          rem0 !== 21'(e.rem)) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v/r/b=%b q=%h rem=%h want 101 q=%h rem=%h",
                 i, {out_valid0, in_ready0, busy0}, q0, rem0, 20'(e.q), 21'(e.rem));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    e = sb0.pop_front();
    checks++;
    if (q0 !== 20'(e.q) || rem0 !== 21'(e.rem)) begin
      errors++;
      $display("FAIL trunc_result a=%h got q=%h rem=%h want q=%h rem=%h",
               a, q0, rem0, 20'(e.q), 21'(e.rem));
    end
    checks++;
    if (q1 !== 20'(e.qr) || rem1 !== 21'(e.rem)) begin
      errors++;
      $display("FAIL round_result a=%h got q=%h rem=%h want q=%h rem=%h",
               a, q1, rem1, 20'(e.qr), 21'(e.rem));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || q0 !== 20'(e.q)) begin
      errors++;
      $display("FAIL after_xfer got v=%b rdy=%b q=%h want v=0 rdy=1 q=%h",
               out_valid0, in_ready0, q0, 20'(e.q));
    end
  endtask

  task automatic test_basic();
    run_op0(12'h040, 0, 22);
    checks++;
    if (q0 !== 20'h20000 || rem0 !== 21'h0) begin
      errors++;
      $display("FAIL sqrt4 got q=%h rem=%h want q=20000 rem=0", q0, rem0);
    end
    run_op0(12'h020, 0, 22);
    checks++;
    if (q0 !== 20'h16A09 || q1 !== 20'h16A0A || rem0 !== rem1) begin
      errors++;
      $display("FAIL sqrt2 got q0=%h q1=%h rem0=%h rem1=%h want 16a09 16a0a equal rem",
               q0, q1, rem0, rem1);
    end
    run_op0(12'hFFF, 0, 22);
    checks++;
    if (q0 !== 20'hFFF7F || q1 !== 20'hFFF80) begin
      errors++;
      $display("FAIL sqrt_max got q0=%h q1=%h want fff7f fff80", q0, q1);
    end
    run_op0(12'h000, 0, 2);
    checks++;
    if (q0 !== 20'h0 || rem0 !== 21'h0 || q1 !== 20'h0) begin
      errors++;
      $display("FAIL sqrt0 got q0=%h rem0=%h q1=%h want 0", q0, rem0, q1);
    end
  endtask

  task automatic test_stall();
    run_op0(12'h0A7, 10, 22);
  endtask

  task automatic test_reset_mid();
    bit spurious = 1'b0;
    in_valid = 1'b1;
    a0       = 12'h123;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", busy0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid0, busy0, in_ready0} !== 3'b001 || q0 !== '0 || rem0 !== '0) begin
      errors++;
      $display("FAIL mid_reset got v/b/r=%b q=%h rem=%h want 001 q=0 rem=0",
               {out_valid0, busy0, in_ready0}, q0, rem0);
    end
    #2;
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL mid_spurious got out_valid=1 after reset want 0");
    end
    run_op0(12'h090, 0, 22);
    checks++;
    if (q0 !== 20'h30000 || rem0 !== 21'h0) begin
      errors++;
      $display("FAIL sqrt9 got q=%h rem=%h want q=30000 rem=0", q0, rem0);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] tbl[6];
    logic [11:0] prev_a = '0;
    logic [19:0] qs0, qs1;
    logic [20:0] rs0;
    logic        acc, xfer;
    int          idx = 0, got = 0, cyc = 0, last_acc = 0, gap;
    bit          first = 1'b1;
    exp_t        e;
    tbl       = '{12'h001, 12'h0FF, 12'h000, 12'h800, 12'h3C4, 12'hFFE};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a0        = tbl[0];
    while (got < 6 && cyc < 400) begin
      acc  = in_valid & in_ready0;
      xfer = out_valid0 & out_ready;
      qs0  = q0;
      qs1  = q1;
      rs0  = rem0;
      @(posedge clk);
      if (acc) begin
        sb0.push_back(model(tbl[idx], 28, 20));
        if (!first) begin
          gap = (prev_a == '0) ? 3 : 23;
          checks++;
          if (cyc - last_acc != gap) begin
            errors++;
            $display("FAIL b2b_gap got %0d want %0d", cyc - last_acc, gap);
          end
        end
        first    = 1'b0;
        last_acc = cyc;
        prev_a   = tbl[idx];
        idx++;
      end
      if (xfer) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got unexpected output want none");
        end else begin
          e = sb0.pop_front();
          if (qs0 !== 20'(e.q) || rs0 !== 21'(e.rem) || qs1 !== 20'(e.qr)) begin
            errors++;
            $display("FAIL b2b_result got q0=%h rem=%h q1=%h want %h %h %h",
                     qs0, rs0, qs1, 20'(e.q), 21'(e.rem), 20'(e.qr));
          end
        end
        got++;
      end
      #1;
      cyc++;
      if (idx >= 6) in_valid = 1'b0;
      else a0 = tbl[idx];
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL b2b_timeout got %0d results want 6", got);
    end
  endtask

  task automatic test_random_0(input int n);
    int          sent = 0, got = 0, cyc = 0;
    logic        acc, xfer;
    logic [11:0] as;
    logic [19:0] qs0, qs1;
    logic [20:0] rs0, rs1;
    exp_t        e;
    while (got < n && cyc < n * 40 + 100) begin
      in_valid = (sent < n) && ($urandom_range(3) != 0);
      case ($urandom_range(9))
        0:       a0 = 12'h000;
        1:       a0 = 12'hFFF;
        default: a0 = 12'($urandom);
      endcase
      out_ready = ($urandom_range(3) != 0);
      as   = a0;
      acc  = in_valid & in_ready0;
      xfer = out_valid0 & out_ready;
      qs0  = q0;
      qs1  = q1;
      rs0  = rem0;
      rs1  = rem1;
      @(posedge clk);
      if (acc) begin
        sb0.push_back(model(as, 28, 20));
        sent++;
      end
      if (xfer) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL rand0_extra got unexpected output want none");
        end else begin
          e = sb0.pop_front();
          if (qs0 !== 20'(e.q) || rs0 !== 21'(e.rem) || qs1 !== 20'(e.qr) ||
              rs1 !== 21'(e.rem)) begin
            errors++;
            $display("FAIL rand0_result got q0=%h rem0=%h q1=%h rem1=%h want %h %h %h %h",
                     qs0, rs0, qs1, rs1, 20'(e.q), 21'(e.rem), 20'(e.qr), 21'(e.rem));
          end
        end
        got++;
      end
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL rand0_timeout got %0d results want %0d", got, n);
    end
  endtask

  task automatic test_random_b(input int n);
    int         sent = 0, got = 0, cyc = 0;
    logic       acc, xfer;
    logic [7:0] as;
    logic [3:0] qs;
    logic [4:0] rs;
    exp_t       e;
    while (got < n && cyc < n * 20 + 100) begin
      in_valid_b = (sent < n) && ($urandom_range(3) != 0);
      case ($urandom_range(9))
        0:       a_b = 8'h00;
        1:       a_b = 8'hFF;
        default: a_b = 8'($urandom);
      endcase
      out_ready_b = ($urandom_range(3) != 0);
      as   = a_b;
      acc  = in_valid_b & in_ready_b;
      xfer = out_valid_b & out_ready_b;
      qs   = q_b;
      rs   = rem_b;
      @(posedge clk);
      if (acc) begin
        sb_b.push_back(model(as, 0, 4));
        sent++;
      end
      if (xfer) begin
        checks++;
        if (sb_b.size() == 0) begin
          errors++;
          $display("FAIL randb_extra got unexpected output want none");
        end else begin
          e = sb_b.pop_front();
          if (qs !== 4'(e.qr) || rs !== 5'(e.rem)) begin
            errors++;
            $display("FAIL randb_result got q=%h rem=%h want q=%h rem=%h",
                     qs, rs, 4'(e.qr), 5'(e.rem));
          end
        end
        got++;
      end
      #1;
      cyc++;
    end
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL randb_timeout got %0d results want %0d", got, n);
    end
  endtask

  task automatic test_random_c(input int n);
    int          sent = 0, got = 0, cyc = 0;
    logic        acc, xfer;
    logic [15:0] as;
    logic [14:0] qs;
    logic [15:0] rs;
    exp_t        e;
    while (got < n && cyc < n * 30 + 100) begin
      in_valid_c = (sent < n) && ($urandom_range(3) != 0);
      case ($urandom_range(9))
        0:       a_c = 16'h0000;
        1:       a_c = 16'hFFFF;
        default: a_c = 16'($urandom);
      endcase
      out_ready_c = ($urandom_range(3) != 0);
      as   = a_c;
      acc  = in_valid_c & in_ready_c;
      xfer = out_valid_c & out_ready_c;
      qs   = q_c;
      rs   = rem_c;
      @(posedge clk);
      if (acc) begin
        sb_c.push_back(model(as, 13, 15));
        sent++;
      end
      if (xfer) begin
        checks++;
        if (sb_c.size() == 0) begin
          errors++;
          $display("FAIL randc_extra got unexpected output want none");
        end else begin
          e = sb_c.pop_front();
          if (qs !== 15'(e.q) || rs !== 16'(e.rem)) begin
            errors++;
            $display("FAIL randc_result got q=%h rem=%h want q=%h rem=%h",
                     qs, rs, 15'(e.q), 16'(e.rem));
          end
        end
        got++;
      end
      #1;
      cyc++;
    end
    in_valid_c  = 1'b0;
    out_ready_c = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL randc_timeout got %0d results want %0d", got, n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    fork
      test_random_0(1200);
      test_random_b(3000);
      test_random_c(1500);
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
